// File: rtl/mem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_pkg
// Shared definitions for the MEM-stage memory access controller:
//   - funct3 load/store width encodings
//   - ResultSrc code that marks a load
//   - controller FSM state encoding
//   - access size decode and alignment helper
// -----------------------------------------------------------------------------
package mem_access_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_t;

    // Unsupported encodings (011, 110, 111) fall through to word size.
    function automatic size_t access_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (access_size(f3))
            SZ_H:    return addr_lo[0];
            SZ_W:    return (addr_lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Combinational load-lane selection and sign/zero extension.
// Ports:
//   rdata   in  32  raw word returned by memory
//   funct3  in  3   load width/signedness
//   addr_lo in  2   byte offset within the word
//   data    out 32  extended load result
// -----------------------------------------------------------------------------
module load_extend
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        // Halfwords are aligned, so only addr_lo[1] picks the lane.
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// MEM-stage controller that turns a pipeline load/store into a single
// request/acknowledge memory transaction (IDLE -> BUSY -> DONE) and stalls
// the pipeline while the transaction is in flight.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   MemWriteM, ResultSrcM  store flag / result source (01 = load)
//   funct3M                access width and signedness
//   ALUResultM, WriteDataM byte address and store data
//   mem_req/we/addr/wdata/be  memory request bus (valid during BUSY)
//   mem_rdata, mem_ack     memory read word and one-cycle completion
//   ReadDataM              extended load result, held until next completion
//   StallM                 stall request to IF/ID/EX/MEM
//   MisalignM              misaligned access detected and dropped
//   TimeoutM               one-cycle pulse when mem_ack never arrived
// -----------------------------------------------------------------------------
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWriteM,
    input  logic [1:0]        ResultSrcM,
    input  logic [2:0]        funct3M,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [31:0]       WriteDataM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       ReadDataM,
    output logic              StallM,
    output logic              MisalignM,
    output logic              TimeoutM
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  busy_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              timeout_q;
    logic [31:0]       read_data_q;

    logic              access;
    logic              misaligned;
    logic              capture;
    logic              ack_done;
    logic              timeout_hit;
    logic              busy;
    logic [31:0]       load_value;
    logic [31:0]       wdata_calc;
    logic [3:0]        be_calc;

    load_extend u_load_extend (
        .rdata   (mem_rdata),
        .funct3  (funct3_q),
        .addr_lo (addr_q[1:0]),
        .data    (load_value)
    );

    // Store lane formatting and byte enables, computed from the pipeline
    // inputs so they can be frozen in registers at capture time.
    always_comb begin
        wdata_calc = '0;
        be_calc    = 4'b1111;
        if (MemWriteM) begin
            case (access_size(funct3M))
                SZ_B: begin
                    wdata_calc = {4{WriteDataM[7:0]}};
                    be_calc    = 4'b0001 << ALUResultM[1:0];
                end
                SZ_H: begin
                    wdata_calc = {2{WriteDataM[15:0]}};
                    be_calc    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    wdata_calc = WriteDataM;
                    be_calc    = 4'b1111;
                end
            endcase
        end
    end

    // Next-state and combinational outputs.
    always_comb begin
        access      = MemWriteM || (ResultSrcM == RESULT_SRC_LOAD);
        misaligned  = is_misaligned(funct3M, ALUResultM[1:0]);
        state_next  = state;
        capture     = 1'b0;
        ack_done    = 1'b0;
        timeout_hit = 1'b0;
        StallM      = 1'b0;
        MisalignM   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        MisalignM = 1'b1;
                    end else begin
                        capture    = 1'b1;
                        StallM     = 1'b1;
                        state_next = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                StallM = 1'b1;
                if (mem_ack) begin
                    ack_done   = 1'b1;
                    state_next = ST_DONE;
                end else if (busy_cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        // The IDLE decode is purely combinational, so reset must mask it
        // explicitly to keep every output low while reset is held.
        if (reset) begin
            StallM    = 1'b0;
            MisalignM = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            busy_cnt    <= '0;
            addr_q      <= '0;
            funct3_q    <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            timeout_q   <= 1'b0;
            read_data_q <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                addr_q    <= ALUResultM;
                funct3_q  <= funct3M;
                we_q      <= MemWriteM;
                wdata_q   <= wdata_calc;
                be_q      <= be_calc;
                busy_cnt  <= '0;
                timeout_q <= 1'b0;
            end else if (state == ST_BUSY) begin
                busy_cnt <= busy_cnt + CNT_W'(1);
            end
            if (ack_done) begin
                read_data_q <= we_q ? 32'd0 : load_value;
            end
            if (timeout_hit) begin
                read_data_q <= 32'd0;
                timeout_q   <= 1'b1;
            end
        end
    end

    // The request bus is only driven during BUSY; otherwise it idles at 0.
    assign busy      = (state == ST_BUSY);
    assign mem_req   = busy;
    assign mem_we    = busy & we_q;
    assign mem_addr  = busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata = busy ? wdata_q : '0;
    assign mem_be    = busy ? be_q : '0;
    assign ReadDataM = read_data_q;
    assign TimeoutM  = (state == ST_DONE) && timeout_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed self-checking bench for mem_access_ctrl.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MisalignM;
    logic        TimeoutM;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.TIMEOUT_CYC(16), .ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .TimeoutM   (TimeoutM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Drives one access and records what the DUT did; comparisons are made
    // by the calling test. ack_at = BUSY cycle index (1-based) carrying
    // mem_ack, 0 = never acknowledge.
    task automatic run_access(
        input  logic        we,
        input  logic [2:0]  f3,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  int          ack_at,
        input  logic [31:0] rdata,
        output int          stall_n,
        output int          req_n,
        output logic [31:0] addr_o,
        output logic [3:0]  be_o,
        output logic [31:0] wdata_o,
        output logic        we_o,
        output logic        stable_o,
        output logic [31:0] rd_o,
        output logic        to_o,
        output logic        stall_done,
        output logic        finished
    );
        int guard;
        @(negedge clk);
        MemWriteM  = we;
        ResultSrcM = we ? 2'b00 : 2'b01;
        funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wdata;
        #1;
        stall_n  = StallM ? 1 : 0;
        req_n    = 0;
        stable_o = 1'b1;
        addr_o   = '0;
        be_o     = '0;
        wdata_o  = '0;
        we_o     = 1'b0;
        guard    = 0;
        @(negedge clk);
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        ALUResultM = '0;
        WriteDataM = '0;
        #1;
        while (mem_req && guard < 40) begin
            if (req_n == 0) begin
                addr_o  = mem_addr;
                be_o    = mem_be;
                wdata_o = mem_wdata;
                we_o    = mem_we;
            end else if (mem_addr !== addr_o || mem_be !== be_o ||
                         mem_wdata !== wdata_o || mem_we !== we_o) begin
                stable_o = 1'b0;
            end
            req_n++;
            if (StallM) stall_n++;
            if (req_n == ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = '0;
            #1;
            guard++;
        end
        finished   = (guard < 40);
        rd_o       = ReadDataM;
        to_o       = TimeoutM;
        stall_done = StallM;
    endtask

    int          s_n, r_n;
    logic [31:0] a_o, wd_o, rd_o;
    logic [3:0]  be_o;
    logic        we_o, st_o, to_o, sd_o, fin_o;

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        // Access requested while reset is held must not stall or flag.
        ResultSrcM = 2'b01; funct3M = 3'b010; ALUResultM = 32'h101;
        #1;
        checks++;
        if ({mem_req, mem_we, StallM, MisalignM, TimeoutM} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000", {mem_req, mem_we, StallM, MisalignM, TimeoutM});
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_be} !== 68'd0) begin
            errors++; $display("FAIL reset_bus got %h/%h/%h want 0", mem_addr, mem_wdata, mem_be);
        end
        checks++;
        if (ReadDataM !== 32'd0) begin
            errors++; $display("FAIL reset_rdata got %h want 0", ReadDataM);
        end
        @(negedge clk);
        ResultSrcM = 2'b00; ALUResultM = '0;
        reset = 1'b0;
    endtask

    task automatic test_lw();
        run_access(1'b0, 3'b010, 32'h104, 32'h0, 2, 32'hDEADBEEF,
                   s_n, r_n, a_o, be_o, wd_o, we_o, st_o, rd_o, to_o, sd_o, fin_o);
        checks++;
        if (s_n !== 3) begin errors++; $display("FAIL lw_stall_cycles got %0d want 3", s_n); end
        checks++;
        if (r_n !== 2) begin errors++; $display("FAIL lw_req_cycles got %0d want 2", r_n); end
        checks++;
        if (a_o !== 32'h104 || be_o !== 4'b1111 || we_o !== 1'b0) begin
            errors++; $display("FAIL lw_bus got addr %h be %b we %b want 104 1111 0", a_o, be_o, we_o);
        end
        checks++;
        if (rd_o !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h want deadbeef", rd_o); end
        checks++;
        if (sd_o !== 1'b0 || to_o !== 1'b0 || st_o !== 1'b1) begin
            errors++; $display("FAIL lw_done got stall %b timeout %b stable %b want 0 0 1", sd_o, to_o, st_o);
        end
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b011};
        logic [31:0] adrs [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
        logic [31:0] rds  [5] = '{32'h80112233, 32'h80112233, 32'h80112233, 32'h80112233, 32'h89ABCDEF};
        logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00008011, 32'h89ABCDEF};
        for (int i = 0; i < 5; i++) begin
            run_access(1'b0, f3s[i], adrs[i], 32'h0, 1, rds[i],
                       s_n, r_n, a_o, be_o, wd_o, we_o, st_o, rd_o, to_o, sd_o, fin_o);
            checks++;
            if (rd_o !== exps[i] || a_o !== {adrs[i][31:2], 2'b00}) begin
                errors++; $display("FAIL load_ext_%0d got %h addr %h want %h", i, rd_o, a_o, exps[i]);
            end
        end
    endtask

    task automatic test_store();
        run_access(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 1, 32'hFFFFFFFF,
                   s_n, r_n, a_o, be_o, wd_o, we_o, st_o, rd_o, to_o, sd_o, fin_o);
        checks++;
        if (we_o !== 1'b1 || be_o !== 4'b1100 || wd_o !== 32'hABCDABCD || a_o !== 32'h200) begin
            errors++; $display("FAIL sh_bus got we %b be %b wdata %h addr %h want 1 1100 abcdabcd 200", we_o, be_o, wd_o, a_o);
        end
        checks++;
        if (rd_o !== 32'd0) begin errors++; $display("FAIL sh_rdata got %h want 0", rd_o); end
        run_access(1'b1, 3'b000, 32'h201, 32'h12345678, 2, 32'h0,
                   s_n, r_n, a_o, be_o, wd_o, we_o, st_o, rd_o, to_o, sd_o, fin_o);
        checks++;
        if (be_o !== 4'b0010 || wd_o !== 32'h78787878 || a_o !== 32'h200 || st_o !== 1'b1) begin
            errors++; $display("FAIL sb_bus got be %b wdata %h addr %h stable %b want 0010 78787878 200 1", be_o, wd_o, a_o, st_o);
        end
        run_access(1'b1, 3'b010, 32'h300, 32'hA5A50F0F, 1, 32'h0,
                   s_n, r_n, a_o, be_o, wd_o, we_o, st_o, rd_o, to_o, sd_o, fin_o);
        checks++;
        if (be_o !== 4'b1111 || wd_o !== 32'hA5A50F0F || a_o !== 32'h300 || we_o !== 1'b1) begin
            errors++; $display("FAIL sw_bus got be %b wdata %h addr %h want 1111 a5a50f0f 300", be_o, wd_o, a_o);
        end
    endtask

    task automatic test_misalign();
        logic        wes  [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s  [3] = '{3'b010, 3'b001, 3'b101};
        logic [31:0] adrs [3] = '{32'h101, 32'h203, 32'h101};
        int          req_seen;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            MemWriteM  = wes[i];
            ResultSrcM = wes[i] ? 2'b00 : 2'b01;
            funct3M    = f3s[i];
            ALUResultM = adrs[i];
            #1;
            checks++;
            if (MisalignM !== 1'b1 || StallM !== 1'b0 || mem_req !== 1'b0) begin
                errors++; $display("FAIL misalign_%0d got mis %b stall %b req %b want 1 0 0", i, MisalignM, StallM, mem_req);
            end
            @(negedge clk);
            MemWriteM = 1'b0; ResultSrcM = 2'b00; ALUResultM = '0;
            req_seen = 0;
            repeat (3) begin
                #1;
                if (mem_req || MisalignM || StallM) req_seen++;
                @(negedge clk);
            end
            checks++;
            if (req_seen !== 0) begin
                errors++; $display("FAIL misalign_after_%0d got %0d active cycles want 0", i, req_seen);
            end
        end
    endtask

    task automatic test_timeout();
        run_access(1'b0, 3'b010, 32'h108, 32'h0, 1, 32'h11112222,
                   s_n, r_n, a_o, be_o, wd_o, we_o, st_o, rd_o, to_o, sd_o, fin_o);
        checks++;
        if (rd_o !== 32'h11112222) begin errors++; $display("FAIL pre_timeout_rdata got %h want 11112222", rd_o); end
        run_access(1'b0, 3'b010, 32'h10C, 32'h0, 0, 32'h0,
                   s_n, r_n, a_o, be_o, wd_o, we_o, st_o, rd_o, to_o, sd_o, fin_o);
        checks++;
        if (fin_o !== 1'b1 || r_n !== 16) begin
            errors++; $display("FAIL timeout_req_cycles got %0d (ended %b) want 16", r_n, fin_o);
        end
        checks++;
        if (to_o !== 1'b1 || rd_o !== 32'd0 || sd_o !== 1'b0) begin
            errors++; $display("FAIL timeout_done got to %b rdata %h stall %b want 1 0 0", to_o, rd_o, sd_o);
        end
        @(negedge clk); #1;
        checks++;
        if (TimeoutM !== 1'b0 || mem_req !== 1'b0 || StallM !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse got to %b req %b stall %b want 0 0 0", TimeoutM, mem_req, StallM);
        end
    endtask

    task automatic test_reset_mid();
        run_access(1'b0, 3'b010, 32'h114, 32'h0, 1, 32'h5A5A1234,
                   s_n, r_n, a_o, be_o, wd_o, we_o, st_o, rd_o, to_o, sd_o, fin_o);
        @(negedge clk);
        ResultSrcM = 2'b01; funct3M = 3'b010; ALUResultM = 32'h110;
        @(negedge clk);
        ResultSrcM = 2'b00; ALUResultM = '0;
        #1;
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_busy1 got req %b want 1", mem_req); end
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_we, StallM, MisalignM, TimeoutM} !== 5'b0 || {mem_addr, mem_wdata, mem_be} !== 68'd0) begin
            errors++; $display("FAIL rstmid_outputs got req %b stall %b addr %h be %b want all 0", mem_req, StallM, mem_addr, mem_be);
        end
        checks++;
        if (ReadDataM !== 32'd0) begin errors++; $display("FAIL rstmid_rdata got %h want 0", ReadDataM); end
        @(negedge clk);
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h77777777;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || StallM !== 1'b0 || ReadDataM !== 32'd0 || TimeoutM !== 1'b0) begin
            errors++; $display("FAIL late_ack got req %b stall %b rdata %h want 0 0 0", mem_req, StallM, ReadDataM);
        end
        run_access(1'b0, 3'b010, 32'h110, 32'h0, 1, 32'h0BADF00D,
                   s_n, r_n, a_o, be_o, wd_o, we_o, st_o, rd_o, to_o, sd_o, fin_o);
        checks++;
        if (rd_o !== 32'h0BADF00D || r_n !== 1 || a_o !== 32'h110) begin
            errors++; $display("FAIL post_reset_lw got %h req %0d addr %h want 0badf00d 1 110", rd_o, r_n, a_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] adrs [2] = '{32'h120, 32'h124};
        logic [31:0] rds  [2] = '{32'hCAFEF00D, 32'h01234567};
        for (int i = 0; i < 2; i++) begin
            run_access(1'b0, 3'b010, adrs[i], 32'h0, 1, rds[i],
                       s_n, r_n, a_o, be_o, wd_o, we_o, st_o, rd_o, to_o, sd_o, fin_o);
            checks++;
            if (s_n !== 2 || r_n !== 1 || sd_o !== 1'b0) begin
                errors++; $display("FAIL b2b_timing_%0d got stall %0d req %0d done_stall %b want 2 1 0", i, s_n, r_n, sd_o);
            end
            checks++;
            if (rd_o !== rds[i] || a_o !== adrs[i]) begin
                errors++; $display("FAIL b2b_data_%0d got %h addr %h want %h %h", i, rd_o, a_o, rds[i], adrs[i]);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        funct3M    = 3'b000;
        ALUResultM = '0;
        WriteDataM = '0;
        mem_rdata  = '0;
        mem_ack    = 1'b0;
        test_reset();
        test_lw();
        test_load_extend();
        test_store();
        test_misalign();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
